// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: commits ALU results and formats load data into the regfile
//
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   in_valid/in_waddr/in_wvalid/in_result/in_is_load/in_funct3 : instruction from MEM
//   flush                   : drop the current-cycle input (IDLE only)
//   mem_rdata, mem_ack      : word-aligned data-memory read response
//   waddr, wdata, wvalid    : regfile write port (wvalid is a one-cycle pulse)
//   stall_req               : combinational hold request while a load waits for memory
//   load_err                : one-cycle pulse when a misaligned/illegal load is dropped
//   mem_timeout             : sticky flag, a load never received mem_ack
module wb_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_waddr,
  input  logic        in_wvalid,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic        flush,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        wvalid,
  output logic        stall_req,
  output logic        load_err,
  output logic        mem_timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]  r_ld_waddr;
  logic        r_ld_wvalid;
  logic [2:0]  r_ld_funct3;
  logic [1:0]  r_ld_addr;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_wvalid;
  logic        r_load_err;
  logic        r_mem_timeout;

  logic        w_load_ok;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  // Legal funct3 and natural alignment of the load address.
  always_comb begin
    w_load_ok = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: w_load_ok = 1'b1;
      3'b001, 3'b101: w_load_ok = ~in_result[0];
      3'b010:         w_load_ok = (in_result[1:0] == 2'b00);
      default:        w_load_ok = 1'b0;
    endcase
  end

  // Lane select and extension of the returned word using the captured address.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_ld_addr)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_ld_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_fmt  = mem_rdata;
    case (r_ld_funct3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_fmt = {24'h0, w_byte};
      3'b101:  w_fmt = {16'h0, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ld_waddr    <= '0;
      r_ld_wvalid   <= 1'b0;
      r_ld_funct3   <= '0;
      r_ld_addr     <= '0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_wvalid      <= 1'b0;
      r_load_err    <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_wvalid   <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // mem_ack is deliberately ignored here: no load is outstanding.
          if (in_valid && !flush) begin
            if (!in_is_load) begin
              r_waddr  <= in_waddr;
              r_wdata  <= in_result;
              r_wvalid <= in_wvalid && (in_waddr != 5'd0);
            end else if (w_load_ok) begin
              r_ld_waddr  <= in_waddr;
              r_ld_wvalid <= in_wvalid;
              r_ld_funct3 <= in_funct3;
              r_ld_addr   <= in_result[1:0];
              r_cnt       <= '0;
              r_state     <= S_WAIT;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // Upstream is held by stall_req, so in_valid/flush are not looked at.
          if (mem_ack) begin
            r_waddr  <= r_ld_waddr;
            r_wdata  <= w_fmt;
            r_wvalid <= r_ld_wvalid && (r_ld_waddr != 5'd0);
            r_state  <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            // This cycle brings the count to TIMEOUT: abandon the load.
            r_mem_timeout <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_req   = (r_state == S_WAIT) && !mem_ack;
  assign waddr       = r_waddr;
  assign wdata       = r_wdata;
  assign wvalid      = r_wvalid;
  assign load_err    = r_load_err;
  assign mem_timeout = r_mem_timeout;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port in_valid  input  1  upstream (MEM) instruction present this cycle.
REQ-004 SHALL have port in_waddr  input  5  destination register index.
REQ-005 SHALL have port in_wvalid  input  1  instruction writes a register.
REQ-006 SHALL have port in_result  input  32  ALU result, or load byte address for loads.
REQ-007 SHALL have port in_is_load  input  1  instruction is a load.
REQ-008 SHALL have port in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-009 SHALL have port flush  input  1  discard the current-cycle input.
REQ-010 SHALL have port mem_rdata  input  32  data-memory read word (word-aligned).
REQ-011 SHALL have port mem_ack  input  1  mem_rdata valid this cycle.
REQ-012 SHALL have port waddr  output  5  regfile write index.
REQ-013 SHALL have port wdata  output  32  regfile write data.
REQ-014 SHALL have port wvalid  output  1  regfile write enable; single-cycle pulse.
REQ-015 SHALL have port stall_req  output  1  hold upstream pipeline.
REQ-016 SHALL have port load_err  output  1  one-cycle pulse: misaligned/illegal load dropped.
REQ-017 SHALL have port mem_timeout  output  1  sticky: a load received no mem_ack in time.
REQ-018 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before abort.

Function
REQ-019 SHALL implement two states: IDLE, WAIT.
REQ-020 IDLE, in_valid=1, flush=0, in_is_load=0: next cycle wvalid=in_wvalid&(in_waddr!=0), waddr=in_waddr, wdata=in_result; latency 1.
REQ-021 IDLE, in_valid=1, flush=0, in_is_load=1, legal and aligned load: capture in_waddr, in_wvalid, in_funct3, in_result[1:0]; go WAIT; clear timeout counter.
REQ-022 Alignment: lh/lhu require in_result[0]=0; lw requires in_result[1:0]=00; lb/lbu always aligned.
REQ-023 Misaligned load or funct3 in {011,110,111}: no WAIT, no write; load_err=1 next cycle.
REQ-024 flush=1 in IDLE: input ignored, no write, no error, stay IDLE.
REQ-025 stall_req SHALL be combinational: 1 in WAIT while mem_ack=0; 0 otherwise.
REQ-026 WAIT, mem_ack=1: next cycle wvalid=captured wvalid&(waddr!=0), wdata=formatted data; return IDLE.
REQ-027 Formatting: select byte mem_rdata[8*a+7:8*a] (a=addr[1:0]) or halfword mem_rdata[16*a1+15:16*a1] (a1=addr[1]); lb/lh sign-extend, lbu/lhu zero-extend, lw passes word.
REQ-028 In WAIT, in_valid and flush SHALL be ignored; an in-flight load is committed.
REQ-029 WAIT, mem_ack=0: increment counter; on the cycle counter reaches TIMEOUT, set mem_timeout, go IDLE, no write.
REQ-030 mem_ack in IDLE SHALL be ignored.
REQ-031 wvalid and load_err SHALL be 0 in every cycle not named above; waddr/wdata hold last value.
REQ-032 Write to index 0 SHALL never assert wvalid.

Reset
REQ-033 rst=0: state IDLE, counter 0, waddr=0, wdata=0, wvalid=0, load_err=0, mem_timeout=0; stall_req=0.
REQ-034 rst asserted in WAIT SHALL abandon the load; no write after release.
REQ-035 First capture permitted on first rising clk with rst=1.

Verification
REQ-036 ALU: in_valid=1, in_waddr=5, in_result=0x0000_1234 -> next cycle wvalid=1, waddr=5, wdata=0x0000_1234, stall_req=0.
REQ-037 lb at addr ...01, mem_ack after 3 cycles, mem_rdata=0x1122_8344 -> stall_req=1 for 3 cycles, then wvalid=1, wdata=0xFFFF_FF83.
REQ-038 lhu addr ...10, immediate ack, mem_rdata=0x8001_0000 -> wdata=0x0000_8001; lw addr ...10 -> load_err=1, no wvalid, no stall.
REQ-039 Load to x0, ack, mem_rdata=0xDEAD_BEEF -> no wvalid; ALU to x0 -> no wvalid.
REQ-040 Load with no ack for TIMEOUT cycles -> mem_timeout=1 (sticky), stall_req=0, no wvalid; later ack ignored.
REQ-041 flush=1 with in_valid=1 in IDLE -> no write; rst=0 mid-WAIT -> all outputs 0, no write after release.
